fetch_sequencer: RTL and testbench

- Supplies instructions to control_unit and carries out the PC-select, PC-load and status-load fields that control_unit produces.
- Holds the program counter, the instruction register and the registered {V,C,N,Z} status register.
- Runs a req/ack fetch handshake with instruction memory.
- Returns the 5-bit status bus {V,C,N,Z registered, Z instant} that control_unit consumes.

---
 rtl/legv8_pkg.sv | 24 ++
 rtl/pc_next_logic.sv | 35 +++
 rtl/fetch_sequencer.sv | 82 ++++++++
 tb/tb_fetch_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared encodings for the LEGv8 fetch/sequencing datapath: PC-select codes,
// sequencer FSM states and status-bit positions.
package legv8_pkg;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  localparam int STAT_V = 3;
  localparam int STAT_C = 2;
  localparam int STAT_N = 1;
  localparam int STAT_Z = 0;

  // Instruction addresses are word aligned; low bits are dropped, never trapped.
  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: hold, increment, absolute load or
// PC-relative branch, always returning a word-aligned address.
module pc_next_logic
  import legv8_pkg::*;
(
  input  logic [63:0] pc,
  input  logic [1:0]  cw_ps,
  input  logic        cw_pcsel,
  input  logic [63:0] cw_k,
  input  logic [63:0] reg_a,
  output logic [63:0] next_pc
);

  logic [63:0] w_in;
  logic [63:0] w_pc_plus4;
  logic [63:0] w_raw;

  assign w_in       = cw_pcsel ? cw_k : reg_a;
  assign w_pc_plus4 = pc + 64'd4;

  // Arithmetic wraps modulo 2^64 by construction of the 64-bit adders.
  always_comb begin
    w_raw = pc;
    case (cw_ps)
      PS_HOLD: w_raw = pc;
      PS_INC:  w_raw = w_pc_plus4;
      PS_LOAD: w_raw = w_in;
      PS_REL:  w_raw = w_pc_plus4 + (w_in << 2);
      default: w_raw = pc;
    endcase
  end

  assign next_pc = word_align(w_raw);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns PC, IR and the registered status flags, runs the
// req/ack instruction fetch and applies the control word's PC/status fields.
module fetch_sequencer
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic [1:0]  cw_ps,
  input  logic        cw_pcsel,
  input  logic [63:0] cw_k,
  input  logic        cw_sl,
  input  logic        cw_ns,
  input  logic [63:0] reg_a,
  input  logic [3:0]  alu_status,
  input  logic        stall,
  output logic [4:0]  status,
  output logic [63:0] pc,
  output logic [1:0]  fsm_state
);

  // Handshake: imem_req is held high for the whole of FETCH with imem_addr
  // stable; the transfer completes on the rising edge where imem_ack is high.
  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic [31:0] r_ir;
  logic [3:0]  r_status;
  logic [63:0] w_next_pc;

  pc_next_logic u_pc_next (
    .pc       (r_pc),
    .cw_ps    (cw_ps),
    .cw_pcsel (cw_pcsel),
    .cw_k     (cw_k),
    .reg_a    (reg_a),
    .next_pc  (w_next_pc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_pc     <= word_align(RESET_PC);
      r_ir     <= 32'h0;
      r_status <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // A stall freezes the whole instruction, including any status load.
          if (!stall) begin
            r_pc <= w_next_pc;
            if (cw_sl) r_status <= alu_status;
            if (!cw_ns) r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ST_EXEC);
  assign instruction = r_ir;
  assign status      = {r_status, alu_status[STAT_Z]};
  assign pc          = r_pc;
  assign fsm_state   = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetch handshake, PC-select modes,
// multi-cycle EXEC, stall/status behaviour and asynchronous reset.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [1:0]  cw_ps;
  logic        cw_pcsel;
  logic [63:0] cw_k;
  logic        cw_sl;
  logic        cw_ns;
  logic [63:0] reg_a;
  logic [3:0]  alu_status;
  logic        stall;
  logic [4:0]  status;
  logic [63:0] pc;
  logic [1:0]  fsm_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];

  localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2;

  fetch_sequencer #(.RESET_PC(64'h0)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .cw_ps       (cw_ps),
    .cw_pcsel    (cw_pcsel),
    .cw_k        (cw_k),
    .cw_sl       (cw_sl),
    .cw_ns       (cw_ns),
    .reg_a       (reg_a),
    .alu_status  (alu_status),
    .stall       (stall),
    .status      (status),
    .pc          (pc),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Waits (bounded) for imem_req, then returns a zero-wait ack with word w.
  task automatic do_fetch(input string tag, input logic [31:0] w);
    int waited = 0;
    while (!imem_req && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, "_req"}, {63'h0, imem_req}, 64'h1);
    if (exp_q.size() != 0) chk({tag, "_addr"}, imem_addr, exp_q.pop_front());
    imem_ack   = 1'b1;
    imem_rdata = w;
    step();
    imem_ack   = 1'b0;
    chk({tag, "_valid"}, {63'h0, instr_valid}, 64'h1);
  endtask

  task automatic set_cw(input logic [1:0] ps, input logic sel, input logic [63:0] k,
                        input logic [63:0] a, input logic ns);
    cw_ps = ps; cw_pcsel = sel; cw_k = k; reg_a = a; cw_ns = ns;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    cw_ps = 2'b00; cw_pcsel = 1'b0; cw_k = 64'h0; cw_sl = 1'b0; cw_ns = 1'b0;
    reg_a = 64'h0; alu_status = 4'h0; stall = 1'b0;
    #3;
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_ir", {32'h0, instruction}, 64'h0);
    chk("rst_status", {59'h0, status}, 64'h0);
    step();
    step();
    reset = 1'b0;

    // First fetch: req one edge after release, ack after 3 wait cycles.
    step();
    chk("f0_req", {63'h0, imem_req}, 64'h1);
    chk("f0_addr", imem_addr, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("f0_wait_req", {63'h0, imem_req}, 64'h1);
    end
    imem_ack = 1'b1; imem_rdata = 32'h9100_0421;
    step();
    imem_ack = 1'b0;
    chk("f0_ir", {32'h0, instruction}, 64'h9100_0421);
    chk("f0_valid", {63'h0, instr_valid}, 64'h1);
    chk("f0_req_low", {63'h0, imem_req}, 64'h0);

    // Sequential PC+4 with zero-wait memory: one instruction per 2 cycles.
    set_cw(2'b01, 1'b0, 64'h0, 64'h0, 1'b0);
    step();
    chk("inc_state", {62'h0, fsm_state}, {62'h0, S_FETCH});
    exp_q.push_back(64'h4);
    do_fetch("inc4", 32'h1111_1111);
    exp_q.push_back(64'h8);
    step();
    do_fetch("inc8", 32'h2222_2222);

    // Absolute load to 0x100, then relative branch by -2 words.
    set_cw(2'b10, 1'b1, 64'h100, 64'h0, 1'b0);
    step();
    chk("load_k", pc, 64'h100);
    do_fetch("rel", 32'hB400_0000);
    set_cw(2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b0);
    step();
    chk("rel_neg", pc, 64'hFC);

    // Misaligned register target is truncated.
    do_fetch("br", 32'hD61F_0000);
    set_cw(2'b10, 1'b0, 64'h0, 64'h2003, 1'b0);
    step();
    chk("br_trunc", pc, 64'h2000);

    // Wrap-around at the top of the address space.
    do_fetch("wrap_a", 32'h0);
    set_cw(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0);
    step();
    chk("wrap_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch("wrap_b", 32'h0);
    set_cw(2'b01, 1'b0, 64'h0, 64'h0, 1'b0);
    step();
    chk("wrap_zero", pc, 64'h0);

    // Two-cycle instruction; a stray ack during EXEC must be ignored.
    do_fetch("movk", 32'hF280_0000);
    set_cw(2'b00, 1'b0, 64'h0, 64'h0, 1'b1);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0001;
    step();
    imem_ack = 1'b0;
    chk("mc_pc", pc, 64'h0);
    chk("mc_ir", {32'h0, instruction}, 64'hF280_0000);
    chk("mc_state", {62'h0, fsm_state}, {62'h0, S_EXEC});
    set_cw(2'b01, 1'b0, 64'h0, 64'h0, 1'b0);
    step();
    chk("mc_pc2", pc, 64'h4);
    chk("mc_req", {63'h0, imem_req}, 64'h1);

    // Stall blocks the status load; status[0] follows alu_status[0] directly.
    do_fetch("stat", 32'hAB00_0000);
    cw_sl = 1'b1; alu_status = 4'b1010; stall = 1'b1;
    step();
    chk("stall_status", {59'h0, status}, 64'h0);
    chk("stall_pc", pc, 64'h4);
    chk("stall_valid", {63'h0, instr_valid}, 64'h1);
    alu_status = 4'b1011;
    #1;
    chk("z_instant", {59'h0, status}, 64'h01);
    alu_status = 4'b1010; stall = 1'b0;
    step();
    cw_sl = 1'b0;
    chk("status_load", {59'h0, status}, 64'h14);
    alu_status = 4'b0001;
    #1;
    chk("status_z", {59'h0, status}, 64'h15);
    chk("stat_pc", pc, 64'h8);

    // Asynchronous reset during FETCH, then reset colliding with an ack.
    chk("pre_rst_req", {63'h0, imem_req}, 64'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_req", {63'h0, imem_req}, 64'h0);
    chk("arst_pc", pc, 64'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("rst_ack_ir", {32'h0, instruction}, 64'h0);
    chk("rst_ack_state", {62'h0, fsm_state}, {62'h0, S_IDLE});
    reset = 1'b0;
    step();
    chk("idle_ack_ir", {32'h0, instruction}, 64'h0);
    chk("idle_ack_req", {63'h0, imem_req}, 64'h1);
    imem_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
